mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizing for the I$/D$ memory-port arbiter.
package mem_arb_pkg;
  localparam int CPU_ADDR_BITS   = 32;
  localparam int MEM_DATA_BITS   = 128;
  localparam int MEM_DATA_CYCLES = 4;

  function automatic int ceilLog2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two memory clients.
// MEM_ARB_RR_EN: round-robin on ties; otherwise the data cache wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   val0_i,
  input  logic   val1_i,
  input  owner_e prev_owner_i,
  output logic   grant_valid_o,
  output owner_e winner_o
);
  always_comb begin
    grant_valid_o = val0_i | val1_i;
    winner_o      = val1_i ? OWN_DC : OWN_IC;
`ifdef MEM_ARB_RR_EN
    if (val0_i && val1_i) winner_o = (prev_owner_i == OWN_IC) ? OWN_DC : OWN_IC;
`else
    if (val0_i && val1_i) winner_o = OWN_DC;
`endif
  end

  // Previous owner only matters for round-robin.
  logic unused_prev;
  assign unused_prev = prev_owner_i;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between I$ (c0) and D$ (c1), one transaction at a time.
// Tie policy set by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS    = CPU_ADDR_BITS - 2 - ceilLog2(MEM_DATA_BITS / 32),
  parameter int DATA_BITS    = MEM_DATA_BITS,
  parameter int REFILL_BEATS = MEM_DATA_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req_val,
  output logic                   c0_req_rdy,
  input  logic [ADDR_BITS-1:0]   c0_req_addr,
  input  logic                   c0_req_rw,
  input  logic                   c0_req_data_valid,
  output logic                   c0_req_data_ready,
  input  logic [DATA_BITS-1:0]   c0_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
  input  logic [1:0]             c0_req_data_offset,
  output logic                   c0_resp_val,
  output logic                   c0_resp_nack,
  output logic [DATA_BITS-1:0]   c0_resp_data,
  input  logic                   c1_req_val,
  output logic                   c1_req_rdy,
  input  logic [ADDR_BITS-1:0]   c1_req_addr,
  input  logic                   c1_req_rw,
  input  logic                   c1_req_data_valid,
  output logic                   c1_req_data_ready,
  input  logic [DATA_BITS-1:0]   c1_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
  input  logic [1:0]             c1_req_data_offset,
  output logic                   c1_resp_val,
  output logic                   c1_resp_nack,
  output logic [DATA_BITS-1:0]   c1_resp_data,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic [1:0]             mem_req_data_offset,
  input  logic                   mem_resp_val,
  input  logic                   mem_resp_nack,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int BEAT_W = (REFILL_BEATS > 1) ? ceilLog2(REFILL_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(REFILL_BEATS - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic   grant_valid;
  owner_e winner;

  mem_arb_pick u_pick (
    .val0_i        (c0_req_val),
    .val1_i        (c1_req_val),
    .prev_owner_i  (owner_q),
    .grant_valid_o (grant_valid),
    .winner_o      (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DC;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

  logic own_dc, sel_rw, sel_dv, payload_en;
  assign own_dc     = (owner_q == OWN_DC);
  assign sel_rw     = own_dc ? c1_req_rw : c0_req_rw;
  assign sel_dv     = own_dc ? c1_req_data_valid : c0_req_data_valid;
  assign payload_en = (state_q == ST_REQ) || (state_q == ST_WDATA);

  // Owner-side handshakes, demuxed to the owning client below.
  logic req_rdy, data_ready, rsp_val, rsp_nack;

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    beat_d             = beat_q;
    req_rdy            = 1'b0;
    data_ready         = 1'b0;
    rsp_val            = 1'b0;
    rsp_nack           = 1'b0;
    mem_req_val        = 1'b0;
    mem_req_data_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = winner;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_val = 1'b1;
        req_rdy     = mem_req_rdy;
        if (mem_req_rdy) begin
          if (sel_rw) state_d = ST_WDATA;
          else begin
            state_d = ST_RESP;
            beat_d  = '0;
          end
        end
      end
      ST_WDATA: begin
        mem_req_data_valid = sel_dv;
        data_ready         = mem_req_data_ready;
        if (sel_dv && mem_req_data_ready) state_d = ST_IDLE;
      end
      ST_RESP: begin
        // A nack overrides a coincident data beat.
        rsp_nack = mem_resp_nack;
        rsp_val  = mem_resp_val & ~mem_resp_nack;
        if (mem_resp_nack) state_d = ST_IDLE;
        else if (mem_resp_val) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign c0_req_rdy        = req_rdy & ~own_dc;
  assign c1_req_rdy        = req_rdy & own_dc;
  assign c0_req_data_ready = data_ready & ~own_dc;
  assign c1_req_data_ready = data_ready & own_dc;
  assign c0_resp_val       = rsp_val & ~own_dc;
  assign c1_resp_val       = rsp_val & own_dc;
  assign c0_resp_nack      = rsp_nack & ~own_dc;
  assign c1_resp_nack      = rsp_nack & own_dc;
  assign c0_resp_data      = mem_resp_data;
  assign c1_resp_data      = mem_resp_data;

  assign mem_req_addr        = !payload_en ? '0 : (own_dc ? c1_req_addr : c0_req_addr);
  assign mem_req_rw          = payload_en & sel_rw;
  assign mem_req_data_bits   = !payload_en ? '0 : (own_dc ? c1_req_data_bits : c0_req_data_bits);
  assign mem_req_data_mask   = !payload_en ? '0 : (own_dc ? c1_req_data_mask : c0_req_data_mask);
  assign mem_req_data_offset = !payload_en ? '0 : (own_dc ? c1_req_data_offset : c0_req_data_offset);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: client/memory drivers plus a transaction-level arbitration model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AB = CPU_ADDR_BITS - 2 - ceilLog2(MEM_DATA_BITS / 32);
  localparam int DB = MEM_DATA_BITS;
  localparam int MB = DB / 8;
  localparam int RB = MEM_DATA_CYCLES;

  typedef logic [DB-1:0] w_t;
  typedef struct packed {
    logic [AB-1:0] addr;
    logic          rw;
    logic [DB-1:0] data;
    logic [MB-1:0] mask;
    logic [1:0]    off;
  } tx_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic c0_req_val = 0, c0_req_rw = 0, c0_req_data_valid = 0;
  logic c1_req_val = 0, c1_req_rw = 0, c1_req_data_valid = 0;
  logic [AB-1:0] c0_req_addr = '0, c1_req_addr = '0;
  logic [DB-1:0] c0_req_data_bits = '0, c1_req_data_bits = '0;
  logic [MB-1:0] c0_req_data_mask = '0, c1_req_data_mask = '0;
  logic [1:0]    c0_req_data_offset = '0, c1_req_data_offset = '0;
  logic c0_req_rdy, c0_req_data_ready, c0_resp_val, c0_resp_nack;
  logic c1_req_rdy, c1_req_data_ready, c1_resp_val, c1_resp_nack;
  logic [DB-1:0] c0_resp_data, c1_resp_data;
  logic mem_req_val, mem_req_rw, mem_req_data_valid;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data_bits;
  logic [MB-1:0] mem_req_data_mask;
  logic [1:0]    mem_req_data_offset;
  logic mem_req_rdy = 0, mem_req_data_ready = 0, mem_resp_val = 0, mem_resp_nack = 0;
  logic [DB-1:0] mem_resp_data = '0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy), .c0_req_addr(c0_req_addr), .c0_req_rw(c0_req_rw),
    .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
    .c0_req_data_bits(c0_req_data_bits), .c0_req_data_mask(c0_req_data_mask),
    .c0_req_data_offset(c0_req_data_offset),
    .c0_resp_val(c0_resp_val), .c0_resp_nack(c0_resp_nack), .c0_resp_data(c0_resp_data),
    .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy), .c1_req_addr(c1_req_addr), .c1_req_rw(c1_req_rw),
    .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
    .c1_req_data_bits(c1_req_data_bits), .c1_req_data_mask(c1_req_data_mask),
    .c1_req_data_offset(c1_req_data_offset),
    .c1_resp_val(c1_resp_val), .c1_resp_nack(c1_resp_nack), .c1_resp_data(c1_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_req_data_offset(mem_req_data_offset),
    .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack), .mem_resp_data(mem_resp_data)
  );

  // Client phases: 0 idle, 1 requesting, 2 sending write data, 3 awaiting read beats.
  tx_t q0[$], q1[$];
  int  cp[2], cgap[2], cbeat[2];
  bit  cdv[2];
  bit  busy;
  int  own, last_win;
  int  rdy_pct, drdy_pct, dv_pct, rv_pct, nack_pct, gap_max;
  bit  nack_once;
  int  n_cmp, n_err;

  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tx_t head(input int c);
    tx_t t = '0;
    if (c == 0 && q0.size() > 0) t = q0[0];
    if (c == 1 && q1.size() > 0) t = q1[0];
    return t;
  endfunction

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DB-1:0] beat_data(input logic [AB-1:0] a, input int b);
    logic [31:0] w;
    w = 32'(a) ^ (32'h9e3779b9 * 32'(b + 1));
    return {(DB/32){w}};
  endfunction

  function automatic tx_t mk(input logic [AB-1:0] a, input logic rw, input logic [MB-1:0] m,
                             input logic [1:0] off);
    tx_t t;
    t.addr = a; t.rw = rw; t.mask = m; t.off = off;
    t.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t;
  endfunction

  function automatic tx_t rnd_tx();
    return mk(AB'($urandom()), 1'($urandom_range(1)), MB'($urandom()), 2'($urandom_range(3)));
  endfunction

  task automatic push(input int c, input tx_t t);
    if (c == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  // Arbitration rule at transaction level: lone requester wins; ties per build policy.
  function automatic int model_pick(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef MEM_ARB_RR_EN
      return 1 - last_win;
`else
      return 1;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  function automatic logic any_out();
    return |{c0_req_rdy, c0_req_data_ready, c0_resp_val, c0_resp_nack, c0_resp_data,
             c1_req_rdy, c1_req_data_ready, c1_resp_val, c1_resp_nack, c1_resp_data,
             mem_req_val, mem_req_addr, mem_req_rw, mem_req_data_valid,
             mem_req_data_bits, mem_req_data_mask, mem_req_data_offset};
  endfunction

  task automatic retire(input int c);
    if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    cp[c]   = 0;
    cdv[c]  = 0;
    cgap[c] = $urandom_range(gap_max);
    busy    = 0;
  endtask

  task automatic knobs(input int r, input int dr, input int dv, input int rv, input int nk, input int g);
    rdy_pct = r; drdy_pct = dr; dv_pct = dv; rv_pct = rv; nack_pct = nk; gap_max = g;
  endtask

  task automatic step();
    tx_t h0, h1, h;
    bit  v0, v1, was_busy;
    logic ordy, odr, orv, orn;
    @(negedge clk);
    for (int c = 0; c < 2; c++)
      if (cp[c] == 2 && !cdv[c]) cdv[c] = ($urandom_range(99) < dv_pct);
    h0 = head(0); h1 = head(1);
    c0_req_val = (cp[0] == 1); c0_req_addr = h0.addr; c0_req_rw = h0.rw;
    c0_req_data_bits = h0.data; c0_req_data_mask = h0.mask; c0_req_data_offset = h0.off;
    c0_req_data_valid = (cp[0] == 2) && cdv[0];
    c1_req_val = (cp[1] == 1); c1_req_addr = h1.addr; c1_req_rw = h1.rw;
    c1_req_data_bits = h1.data; c1_req_data_mask = h1.mask; c1_req_data_offset = h1.off;
    c1_req_data_valid = (cp[1] == 2) && cdv[1];
    mem_req_rdy        = ($urandom_range(99) < rdy_pct);
    mem_req_data_ready = ($urandom_range(99) < drdy_pct);
    if (busy && cp[own] == 3) begin
      mem_resp_val  = ($urandom_range(99) < rv_pct);
      mem_resp_nack = nack_once || ($urandom_range(99) < nack_pct);
      mem_resp_data = beat_data(head(own).addr, cbeat[own]);
    end else begin
      mem_resp_val  = 1'b0;
      mem_resp_nack = 1'b0;
      mem_resp_data = beat_data(AB'($urandom()), 9);
    end
    v0 = c0_req_val; v1 = c1_req_val;
    #1;
    was_busy = busy;
    if (!was_busy || own != 0)
      chk("quiet_c0", w_t'({c0_req_rdy, c0_req_data_ready, c0_resp_val, c0_resp_nack}), '0);
    if (!was_busy || own != 1)
      chk("quiet_c1", w_t'({c1_req_rdy, c1_req_data_ready, c1_resp_val, c1_resp_nack}), '0);
    if (was_busy) begin
      h    = head(own);
      ordy = own ? c1_req_rdy : c0_req_rdy;
      odr  = own ? c1_req_data_ready : c0_req_data_ready;
      orv  = own ? c1_resp_val : c0_resp_val;
      orn  = own ? c1_resp_nack : c0_resp_nack;
      case (cp[own])
        1: begin
          chk("req_val", w_t'({mem_req_val, mem_req_data_valid}), w_t'(2'b10));
          chk("req_addr", w_t'(mem_req_addr), w_t'(h.addr));
          chk("req_rw", w_t'(mem_req_rw), w_t'(h.rw));
          chk("req_rdy_route", w_t'({ordy, odr, orv, orn}), w_t'({mem_req_rdy, 3'b000}));
          if (mem_req_rdy) begin
            if (h.rw) cp[own] = 2;
            else begin
              cp[own]    = 3;
              cbeat[own] = 0;
            end
          end
        end
        2: begin
          chk("wd_valid", w_t'({mem_req_val, mem_req_data_valid}), w_t'({1'b0, cdv[own]}));
          if (cdv[own]) begin
            chk("wd_bits", mem_req_data_bits, h.data);
            chk("wd_mask_off", w_t'({mem_req_data_mask, mem_req_data_offset}), w_t'({h.mask, h.off}));
          end
          chk("wd_ready_route", w_t'({ordy, odr, orv, orn}), w_t'({1'b0, mem_req_data_ready, 2'b00}));
          if (cdv[own] && mem_req_data_ready) retire(own);
        end
        3: begin
          chk("resp_route", w_t'({mem_req_val, ordy, odr, orv, orn}),
              w_t'({3'b000, mem_resp_val & ~mem_resp_nack, mem_resp_nack}));
          if (mem_resp_nack) begin
            cp[own]   = 1;
            busy      = 0;
            nack_once = 0;
          end else if (mem_resp_val) begin
            chk("resp_data", own ? c1_resp_data : c0_resp_data, beat_data(h.addr, cbeat[own]));
            cbeat[own]++;
            if (cbeat[own] == RB) retire(own);
          end
        end
        default: ;
      endcase
    end else begin
      chk("idle_mem", w_t'({mem_req_val, mem_req_data_valid}), '0);
      if (v0 || v1) begin
        own      = model_pick(v0, v1);
        last_win = own;
        busy     = 1;
      end
    end
    for (int c = 0; c < 2; c++)
      if (cp[c] == 0) begin
        if (cgap[c] > 0) cgap[c]--;
        else if (qsize(c) > 0) cp[c] = 1;
      end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("timeout_pending", w_t'(q0.size() + q1.size()), '0);
  endtask

  initial begin
    int n;
    n_cmp = 0; n_err = 0;
    busy = 0; own = 1; last_win = 1; nack_once = 0;
    for (int c = 0; c < 2; c++) begin cp[c] = 0; cgap[c] = 0; cbeat[c] = 0; cdv[c] = 0; end
    knobs(100, 100, 100, 100, 0, 0);
    #12;
    chk("rst_outs", w_t'(any_out()), '0);
    #10 reset = 1'b1;

    // Lone c0 read of 0x1234, memory always ready.
    push(0, mk(AB'(28'h1234), 1'b0, '0, 2'd0));
    run_idle(40);

    // Simultaneous reads, twice over: checks tie order and policy follow-up.
    push(0, mk(AB'($urandom()), 1'b0, '0, 2'd0)); push(1, mk(AB'($urandom()), 1'b0, '0, 2'd0));
    push(0, mk(AB'($urandom()), 1'b0, '0, 2'd0)); push(1, mk(AB'($urandom()), 1'b0, '0, 2'd0));
    run_idle(100);

    // c1 write with a slow memory data channel.
    knobs(100, 25, 100, 100, 0, 0);
    push(1, mk(AB'($urandom()), 1'b1, MB'(16'h000F), 2'd2));
    run_idle(100);

    // c0 read nacked on its first response cycle; c1 arrives while c0 owns the port.
    knobs(100, 100, 100, 100, 0, 0);
    nack_once = 1;
    push(0, mk(AB'($urandom()), 1'b0, '0, 2'd0));
    repeat (3) step();
    push(1, mk(AB'($urandom()), 1'b0, '0, 2'd0));
    run_idle(100);

    // Memory request channel mostly stalled.
    knobs(15, 100, 100, 100, 0, 0);
    for (int i = 0; i < 4; i++) push(i % 2, rnd_tx());
    run_idle(400);

    // Reset asserted mid-refill after beat 1.
    knobs(100, 100, 100, 100, 0, 0);
    push(1, mk(AB'($urandom()), 1'b0, '0, 2'd0));
    n = 0;
    while (!(busy && own == 1 && cp[1] == 3 && cbeat[1] == 2) && n < 50) begin step(); n++; end
    chk("rst_reach_beat", w_t'(cbeat[1]), w_t'(2));
    #2;
    reset = 1'b0;
    {c0_req_val, c1_req_val, c0_req_data_valid, c1_req_data_valid} = '0;
    {mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_nack} = '0;
    mem_resp_data = '0;
    #1;
    chk("rst_mid_outs", w_t'(any_out()), '0);
    q0.delete(); q1.delete();
    for (int c = 0; c < 2; c++) begin cp[c] = 0; cgap[c] = 0; cbeat[c] = 0; cdv[c] = 0; end
    busy = 0; last_win = 1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    push(1, mk(AB'($urandom()), 1'b0, '0, 2'd0));
    run_idle(40);

    // Mixed random traffic.
    knobs(60, 60, 70, 70, 5, 3);
    for (int i = 0; i < 150; i++) push($urandom_range(1), rnd_tx());
    run_idle(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
